// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential RAM read issue, single in-flight tracking, prefetch FIFO to decode.
// Optional IFETCH_PERF_EN adds perf_fetched, a free-running count of instructions handed to decode.
module ifetch_queue #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]     mem_data,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WIDTH-1:0]     instr,
  output logic [WORD_SIZE-1:0] instr_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [WORD_SIZE-1:0] r_fetch_pc;
  logic                 r_inflight;
  logic [WORD_SIZE-1:0] r_inflight_pc;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_fifo_instr [DEPTH];
  logic [WORD_SIZE-1:0] r_fifo_pc    [DEPTH];

  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic [SUM_W-1:0]     w_credit_used;

  assign w_credit_used = SUM_W'(r_count) + SUM_W'(r_inflight);
  assign w_push        = r_inflight && !redirect;
  assign w_pop         = (r_count != '0) && instr_ready && !redirect;

  assign mem_rd_addr = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_head];
  assign instr_pc    = r_fifo_pc[r_head];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and issue decision; redirect freezes the state
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_RUN: begin
        w_issue = !halt && !redirect && (w_credit_used < SUM_W'(DEPTH));
        if (halt && !redirect) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (!halt && !redirect) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Fetch PC and the single outstanding RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= WORD_SIZE'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + WORD_SIZE'(1);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_fifo_instr[r_tail] <= mem_data;
      r_fifo_pc[r_tail]    <= r_inflight_pc;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
    end else if (w_pop) begin
      r_perf_fetched <= r_perf_fetched + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a queue-level reference model predicts the prefetch queue contents
// and fetch address; a negedge monitor compares the DUT head, valid and address against it.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RESET_PC = 0;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_data = '0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ram [256];

  // Reference model state
  entry_t      q_exp[$];
  logic [7:0]  m_fetch_pc = 8'(RESET_PC);
  logic        m_inflight = 1'b0;
  logic [7:0]  m_inflight_pc = '0;
  logic        m_halted = 1'b0;
  int unsigned m_pops = 0;

  ifetch_queue #(
    .WIDTH(32), .WORD_SIZE(8), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_rd_addr(mem_rd_addr),
    .mem_data(mem_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM
  always @(posedge clk) mem_data <= ram[mem_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model, one step per rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q_exp.delete();
        m_fetch_pc    = 8'(RESET_PC);
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_halted      = 1'b0;
        m_pops        = 0;
      end else if (redirect) begin
        q_exp.delete();
        m_fetch_pc = redirect_pc;
        m_inflight = 1'b0;
      end else begin
        bit do_issue;
        do_issue = !m_halted && !halt && (q_exp.size() + int'(m_inflight) < DEPTH);
        if (q_exp.size() > 0 && instr_ready) begin
          void'(q_exp.pop_front());
          m_pops++;
        end
        if (m_inflight) q_exp.push_back('{instr: ram[m_inflight_pc], pc: m_inflight_pc});
        if (do_issue) begin
          m_inflight_pc = m_fetch_pc;
          m_fetch_pc    = m_fetch_pc + 8'd1;
        end
        m_inflight = do_issue;
        m_halted   = halt;
      end
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_addr", 32'(mem_rd_addr), 32'(m_fetch_pc));
      chk("valid", 32'(instr_valid), 32'(q_exp.size() != 0));
      if (instr_valid && q_exp.size() != 0) begin
        chk("instr", instr, q_exp[0].instr);
        chk("instr_pc", 32'(instr_pc), 32'(q_exp[0].pc));
      end
`ifdef IFETCH_PERF_EN
      chk("perf", perf_fetched, m_pops);
`endif
    end
  end

  task automatic drive(input logic rdy, input logic hlt, input logic rd, input logic [7:0] rpc, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      instr_ready = rdy;
      halt        = hlt;
      redirect    = rd;
      redirect_pc = rpc;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    for (int i = 0; i < 8; i++) ram[i] = 32'h11 * (i + 1);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'(RESET_PC));
    instr_ready = 1'b1;
    #1 rst_n = 1'b1;

    // Streaming, then a decode stall that fills the queue
    drive(1'b1, 1'b0, 1'b0, 8'd0, 12);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 1);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 2);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 10);
    chk("stall_addr", 32'(mem_rd_addr), 32'd4);
    chk("stall_count", 32'(q_exp.size()), 32'(DEPTH));
    drive(1'b1, 1'b0, 1'b0, 8'd0, 6);

    // Redirect with a partly filled queue, then across the PC wrap
    drive(1'b0, 1'b0, 1'b0, 8'd0, 3);
    drive(1'b0, 1'b0, 1'b1, 8'd6, 1);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 6);
    drive(1'b1, 1'b0, 1'b1, 8'd254, 1);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8);

    // Halt drains the queue, then resumes sequentially
    drive(1'b1, 1'b1, 1'b0, 8'd0, 6);
    chk("halt_drained", 32'(instr_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8);
    drive(1'b0, 1'b1, 1'b1, 8'd40, 1);
    drive(1'b1, 1'b1, 1'b0, 8'd0, 3);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 6);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 19) == 0), 8'($urandom), 1);
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 1'b0, 1'b0, 8'd0, 6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_addr", 32'(mem_rd_addr), 32'(RESET_PC));
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 12);

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
